// File: rtl/odo_div_mon.sv
// rtl/odo_div_mon.sv - divided-clock monitor: period/high-time measurement, lock, error and timeout flags
module odo_div_mon #(
    parameter int DIV    = 9,
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4,
    parameter int TMO    = 2*DIV+2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             clk_div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             tmo
);
    localparam int TMO_W  = $clog2(TMO + 1);
    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  DIV_C    = CNT_W'(DIV);
    localparam logic [CNT_W-1:0]  HI_FLOOR = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0]  HI_CEIL  = CNT_W'((DIV + 1) / 2);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_N);
    localparam logic [GOOD_W-1:0] GOOD_PRE = GOOD_W'(LOCK_N - 1);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic              mv_q, mv_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic              rise, meas_good, timeout, err_set, tmo_set;

    assign rise      = s2_q & ~s3_q;
    assign meas_good = (per_cnt_q == DIV_C) && ((hi_cnt_q == HI_FLOOR) || (hi_cnt_q == HI_CEIL));
    assign timeout   = (tmo_cnt_q == TMO_LAST) && !rise;

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        good_d    = good_q;
        period_d  = period_q;
        high_d    = high_q;
        mv_d      = 1'b0;
        locked_d  = locked_q;
        err_set   = 1'b0;
        tmo_set   = 1'b0;
        // Disable overrides everything, including a coincident rise.
        if (!en) begin
            state_d   = IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            tmo_cnt_d = '0;
            good_d    = '0;
            locked_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = WAIT_RISE;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    tmo_cnt_d = '0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_d   = MEASURE;
                        per_cnt_d = CNT_W'(1);
                        hi_cnt_d  = CNT_W'(1);
                        tmo_cnt_d = '0;
                    end else if (timeout) begin
                        tmo_set   = 1'b1;
                        good_d    = '0;
                        locked_d  = 1'b0;
                        tmo_cnt_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // The rise cycle itself opens the next window (s2 is high there).
                        period_d  = per_cnt_q;
                        high_d    = hi_cnt_q;
                        mv_d      = 1'b1;
                        per_cnt_d = CNT_W'(1);
                        hi_cnt_d  = CNT_W'(1);
                        tmo_cnt_d = '0;
                        if (meas_good) begin
                            good_d   = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;
                            locked_d = (good_q >= GOOD_PRE);
                        end else begin
                            good_d   = '0;
                            locked_d = 1'b0;
                            err_set  = 1'b1;
                        end
                    end else if (timeout) begin
                        state_d   = WAIT_RISE;
                        tmo_set   = 1'b1;
                        good_d    = '0;
                        locked_d  = 1'b0;
                        tmo_cnt_d = '0;
                    end else begin
                        if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + 1'b1;
                        if (s2_q && (hi_cnt_q != CNT_MAX)) hi_cnt_d = hi_cnt_q + 1'b1;
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        err_d = err_set | (err_q & ~clr);
        tmo_d = tmo_set | (tmo_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            tmo_cnt_q <= '0;
            good_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            mv_q      <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= clk_div_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            good_q    <= good_d;
            period_q  <= period_d;
            high_q    <= high_d;
            mv_q      <= mv_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign period     = period_q;
    assign high_cnt   = high_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign tmo        = tmo_q;
endmodule

// File: tb/tb_odo_div_mon.sv
// tb/tb_odo_div_mon.sv - randomized bench for odo_div_mon against an event-level reference model
module tb_odo_div_mon;
    localparam int NHIST = 16384;

    logic clk = 1'b0;
    logic rst, en, clr, clk_div_in;
    logic [7:0] per0, hi0, per1, hi1;
    logic mv0, lk0, er0, to0, mv1, lk1, er1, to1;

    always #5 clk = ~clk;

    odo_div_mon #(.DIV(9)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .clk_div_in(clk_div_in),
        .period(per0), .high_cnt(hi0), .meas_valid(mv0), .locked(lk0), .err(er0), .tmo(to0)
    );
    odo_div_mon #(.DIV(9), .TMO(400)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .clk_div_in(clk_div_in),
        .period(per1), .high_cnt(hi1), .meas_valid(mv1), .locked(lk1), .err(er1), .tmo(to1)
    );

    int cmp_cnt = 0;
    int mis_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: input history plus per-instance event bookkeeping
    bit inh [NHIST];
    bit rh  [NHIST];
    int mt = 3;
    int tmo_lim [2] = '{20, 400};
    bit m_act [2], m_edge [2];
    int m_last [2], m_orig [2], m_good [2];
    int e_per [2], e_hi [2];
    bit e_mv [2], e_lk [2], e_err [2], e_tmo [2];

    initial for (int k = 0; k < 4; k++) rh[k] = 1'b1;

    function automatic bit s2f(input int t);
        return (rh[t-1] || rh[t-2]) ? 1'b0 : inh[t-2];
    endfunction

    task automatic step(input int i, input bit r);
        bit set_e, set_t;
        int p, h;
        set_e = 1'b0;
        set_t = 1'b0;
        e_mv[i] = 1'b0;
        if (rst) begin
            m_act[i] = 0; m_edge[i] = 0; m_good[i] = 0;
            e_per[i] = 0; e_hi[i] = 0; e_lk[i] = 0; e_err[i] = 0; e_tmo[i] = 0;
            return;
        end
        if (!en) begin
            m_act[i] = 0; m_edge[i] = 0; m_good[i] = 0; e_lk[i] = 0;
        end else if (!m_act[i]) begin
            m_act[i] = 1; m_edge[i] = 0; m_orig[i] = mt;
        end else if (r) begin
            if (m_edge[i]) begin
                p = mt - m_last[i];
                h = 0;
                for (int k = m_last[i]; k < mt; k++) h += int'(s2f(k));
                if (p > 255) p = 255;
                if (h > 255) h = 255;
                e_per[i] = p; e_hi[i] = h; e_mv[i] = 1'b1;
                if (p == 9 && (h == 4 || h == 5)) m_good[i] = (m_good[i] < 4) ? m_good[i] + 1 : 4;
                else begin m_good[i] = 0; set_e = 1'b1; end
                e_lk[i] = (m_good[i] == 4);
            end
            m_edge[i] = 1; m_last[i] = mt; m_orig[i] = mt;
        end else if (mt - m_orig[i] >= tmo_lim[i]) begin
            set_t = 1'b1; m_good[i] = 0; e_lk[i] = 0; m_edge[i] = 0; m_orig[i] = mt;
        end
        e_err[i] = set_e | (e_err[i] & !clr);
        e_tmo[i] = set_t | (e_tmo[i] & !clr);
    endtask

    always @(posedge clk) begin
        bit r;
        mt++;
        inh[mt] = clk_div_in;
        rh[mt]  = rst;
        r = s2f(mt) && !s2f(mt-1);
        for (int i = 0; i < 2; i++) step(i, r);
    end

    int qp0[$], ql0[$], qe0[$], qp1[$], qh1[$], qe1[$];

    always @(negedge clk) begin
        chk("period0", per0, e_per[0]);  chk("high0", hi0, e_hi[0]);
        chk("mv0", mv0, e_mv[0]);        chk("locked0", lk0, e_lk[0]);
        chk("err0", er0, e_err[0]);      chk("tmo0", to0, e_tmo[0]);
        chk("period1", per1, e_per[1]);  chk("high1", hi1, e_hi[1]);
        chk("mv1", mv1, e_mv[1]);        chk("locked1", lk1, e_lk[1]);
        chk("err1", er1, e_err[1]);      chk("tmo1", to1, e_tmo[1]);
        if (mv0) begin qp0.push_back(int'(per0)); ql0.push_back(int'(lk0)); qe0.push_back(int'(er0)); end
        if (mv1) begin qp1.push_back(int'(per1)); qh1.push_back(int'(hi1)); qe1.push_back(int'(er1)); end
    end

    task automatic cyc(input logic d);
        clk_div_in = d;
        @(posedge clk);
        #2;
    endtask

    task automatic per(input int len, input int hi);
        for (int c = 0; c < len; c++) cyc(c < hi);
    endtask

    initial begin
        int j, base, len, hi;
        rst = 1'b1; en = 1'b0; clr = 1'b0; clk_div_in = 1'b0;
        repeat (3) cyc(1'b0);
        chk("rst_period", per0, 0); chk("rst_mv", mv0, 0); chk("rst_locked", lk0, 0);
        chk("rst_err", er0, 0);     chk("rst_tmo", to0, 0);
        rst = 1'b0; en = 1'b1;

        // Nominal divide-by-9: first edge arms, six measurements follow
        repeat (7) per(9, 5);
        chk("p1_count", qp0.size(), 6);
        if (qp0.size() >= 6) begin
            chk("p1_lock_3rd", ql0[2], 0); chk("p1_lock_4th", ql0[3], 1);
            chk("p1_period", qp0[5], 9);   chk("p1_err", qe0[5], 0);
        end

        // One long period, then relock with err sticky, then clr
        base = qp0.size();
        per(10, 5);
        repeat (5) per(9, 4);
        j = -1;
        for (int k = base; k < qp0.size(); k++) if (j < 0 && qp0[k] == 10) j = k;
        chk("p2_found10", j >= 0, 1);
        if (j >= 0 && j + 4 < qp0.size()) begin
            chk("p2_lock_bad", ql0[j], 0);   chk("p2_err_bad", qe0[j], 1);
            chk("p2_relock", ql0[j+4], 1);   chk("p2_err_kept", qe0[j+4], 1);
        end
        clr = 1'b1; cyc(1'b1); clr = 1'b0;
        chk("p2_clr_err", er0, 0);
        per(8, 4);

        // Stall low beyond TMO=20, then resume
        per(30, 5);
        chk("p3_tmo", to0, 1); chk("p3_unlocked", lk0, 0);
        repeat (6) per(9, 5);
        chk("p3_relock", lk0, 1);

        // Stuck high 300 cycles on the TMO=400 instance
        clr = 1'b1; cyc(1'b0); clr = 1'b0;
        base = qp1.size();
        per(305, 300);
        repeat (3) per(9, 5);
        j = -1;
        for (int k = base; k < qp1.size(); k++) if (j < 0 && qp1[k] == 255) j = k;
        chk("p4_found255", j >= 0, 1);
        if (j >= 0) begin chk("p4_high_sat", qh1[j], 255); chk("p4_err", qe1[j], 1); end
        chk("p4_tmo0", to0, 1);

        // Reset mid-measurement, then clr held across a bad period
        repeat (6) per(9, 5);
        chk("p5_locked", lk1, 1);
        cyc(1'b1); cyc(1'b1);
        rst = 1'b1; cyc(1'b1); rst = 1'b0;
        chk("p5_rst_per", per1, 0); chk("p5_rst_hi", hi1, 0); chk("p5_rst_mv", mv1, 0);
        chk("p5_rst_lk", lk1, 0);   chk("p5_rst_err", er1, 0); chk("p5_rst_tmo", to0, 0);
        clr = 1'b1;
        base = qp0.size();
        per(6, 3); repeat (2) per(9, 5); per(7, 3); repeat (2) per(9, 5);
        clr = 1'b0;
        j = -1;
        for (int k = base; k < qp0.size(); k++) if (j < 0 && qp0[k] == 7) j = k;
        chk("p5_found7", j >= 0, 1);
        if (j >= 0) chk("p5_set_wins", qe0[j], 1);

        // Randomized periods, duty, enable drops, clr and reset
        for (int n = 0; n < 150; n++) begin
            len = ($urandom_range(0, 2) != 0) ? 9 : int'($urandom_range(3, 14));
            if ($urandom_range(0, 19) == 0) len = 25;
            hi = (len == 9 && $urandom_range(0, 1) == 1) ? int'($urandom_range(4, 5))
                                                          : int'($urandom_range(1, len - 1));
            for (int c = 0; c < len; c++) begin
                clr = ($urandom_range(0, 15) == 0);
                en  = ($urandom_range(0, 99) != 0);
                rst = ($urandom_range(0, 499) == 0);
                cyc(c < hi);
            end
        end
        rst = 1'b0; en = 1'b1; clr = 1'b0;
        repeat (4) cyc(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end
endmodule

// File: doc/odo_div_mon.md
ODO_DIV_MON -- requirements
Module: odo_div_mon

Interface
REQ-001 Parameters SHALL be, one per line:
- DIV, 9, expected division ratio of the monitored clock (odd or even, 3..255)
- CNT_W, 8, width of period/high-time counters
- LOCK_N, 4, consecutive good periods required to assert locked
- TMO, 2*DIV+2, cycles without a rising edge before timeout
REQ-002 Ports SHALL be, one per line:
- clk  input  1  system clock, the same clock that sources the monitored divider
- rst  input  1  synchronous active-high reset
- en  input  1  monitor enable
- clr  input  1  clears sticky err and tmo flags
- clk_div_in  input  1  divided clock under test
- period  output  CNT_W  last measured period, clk cycles
- high_cnt  output  CNT_W  clk samples high in last period
- meas_valid  output  1  one-cycle pulse, period/high_cnt updated
- locked  output  1  LOCK_N consecutive good periods seen
- err  output  1  sticky, bad period or high time
- tmo  output  1  sticky, no rising edge within TMO cycles
REQ-003 The block SHALL have one clock, clk; reset SHALL be synchronous and active-high on port rst.

Function
REQ-004 clk_div_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3, sampled on clk rising edge only.
REQ-005 FSM states SHALL be IDLE, WAIT_RISE, MEASURE.
REQ-006 IDLE -> WAIT_RISE when en=1; any state -> IDLE when en=0 (counters cleared, locked=0, meas_valid=0, err/tmo held).
REQ-007 WAIT_RISE -> MEASURE on first rise; no measurement produced for that edge.
REQ-008 In MEASURE, period counter SHALL count cycles from one rise to the next (rise-to-rise distance N gives period=N); high counter SHALL count cycles with s2=1 in the same window.
REQ-009 On each rise in MEASURE, period and high_cnt SHALL be registered and meas_valid pulsed high exactly one cycle later; counters restart so back-to-back periods are measured with no gap.
REQ-010 Both counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-011 A measurement SHALL be good iff period==DIV and high_cnt is floor(DIV/2) or ceil(DIV/2).
REQ-012 Good measurement: good counter increments, saturating at LOCK_N; locked=1 when it equals LOCK_N.
REQ-013 Bad measurement: good counter and locked cleared same cycle as meas_valid; err set.
REQ-014 If TMO cycles elapse in WAIT_RISE or MEASURE with no rise: tmo set, good counter and locked cleared, FSM -> WAIT_RISE, no meas_valid.
REQ-015 clr SHALL clear err and tmo next cycle; if a set condition occurs in the same cycle as clr, set wins.
REQ-016 rise coincident with en falling SHALL be ignored (IDLE wins).

Reset
REQ-017 On rst=1 at a clk edge: FSM=IDLE, s1/s2/s3=0, all counters 0, period=0, high_cnt=0, meas_valid=0, locked=0, err=0, tmo=0.
REQ-018 rst SHALL take priority over en and clr; reset mid-measurement SHALL discard the partial period with no meas_valid.

Verification
REQ-019 Bench SHALL cover:
- DIV=9, en=1, 50%-duty divide-by-9 input for 6 periods -> meas_valid every 9 cycles, period=9, high_cnt in {4,5}, locked=1 after 4th valid, err=0.
- After lock, one period of 10 cycles -> meas_valid with period=10, locked=0 and err=1 same cycle; 4 further good periods -> locked=1, err stays 1; clr pulse -> err=0.
- clk_div_in held low 21 cycles after a rise (TMO=20) -> tmo=1, locked=0, no meas_valid; resumed input relocks after 1 WAIT edge + 4 good periods.
- Input stuck high 300 cycles with TMO overridden to 400 -> period and high_cnt saturate at 255, err=1.
- rst asserted mid-MEASURE with locked=1 -> all outputs 0 next cycle; clr and err-set same cycle -> err=1.
